// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR filter family: default taps and the
// sequencer state encoding.
package fir_pkg;

  localparam int unsigned DEFAULT_TAPS = 29;

  localparam int DEFAULT_COEFFS [0:28] = '{
    -1, -2, -3, -5, -6, -5, 0, 10, 25, 45, 67, 90, 110, 123, 128,
    123, 110, 90, 67, 45, 25, 10, 0, -5, -6, -5, -3, -2, -1
  };

  typedef enum logic {
    IDLE,
    MAC
  } state_t;

  // Power-up coefficient for tap k; only the 29-tap build has a default set.
  function automatic int default_coeff(input int unsigned taps, input int unsigned k);
    if (taps == DEFAULT_TAPS && k < DEFAULT_TAPS) begin
      return DEFAULT_COEFFS[k[4:0]];
    end
    return 0;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up and saturate from a wide signed accumulator
// down to a narrower signed sample.
module fir_round_sat #(
  parameter int unsigned IN_W      = 37,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic [IN_W-1:0]  value,
  output logic [OUT_W-1:0] result
);

  // One guard bit so adding the rounding half can never wrap.
  localparam int unsigned SUM_W   = IN_W + 1;
  localparam int unsigned HALF_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic signed [SUM_W-1:0] HALF  = (FRAC_BITS > 0) ? SUM_W'(1) << HALF_SH : '0;
  localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;

  always_comb begin
    sum     = $signed({value[IN_W-1], value}) + HALF;
    shifted = sum >>> FRAC_BITS;
    if (shifted > MAX_V) begin
      result = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      result = MIN_V[OUT_W-1:0];
    end else begin
      result = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fir_filter_mc.sv
// Reprogrammable multi-cycle FIR: one multiply-accumulate per clock over a
// circular sample history, rounded and saturated back to the sample width.
module fir_filter_mc
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned TAPS        = 29,
  parameter int unsigned FRAC_BITS   = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [WIDTH-1:0]         audio_in,
  input  logic                     valid_in,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         filtered_audio,
  output logic                     data_ready,
  output logic                     overrun,
  input  logic                     coeff_we,
  input  logic [$clog2(TAPS)-1:0]  coeff_addr,
  input  logic [COEFF_WIDTH-1:0]   coeff_data
);

  localparam int unsigned AW     = $clog2(TAPS);
  localparam int unsigned PROD_W = WIDTH + COEFF_WIDTH;
  localparam int unsigned ACC_W  = PROD_W + AW;
  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

  state_t state_q, state_d;
  logic   accept_c, mac_c, last_c, coeff_wr_c;

  logic [AW-1:0] wr_ptr_q, tap_q, rd_idx_c;
  logic signed [WIDTH-1:0]       hist_q [TAPS];
  logic [COEFF_WIDTH-1:0]        coeff_q [TAPS];
  logic [COEFF_WIDTH-1:0]        coeff_dflt [TAPS];
  logic signed [COEFF_WIDTH-1:0] coeff_rd_c;
  logic signed [PROD_W-1:0]      prod_c;
  logic signed [ACC_W-1:0]       acc_q, acc_next_c;
  logic [WIDTH-1:0]              result_c;

  // Coefficients are stored XOR-ed with the default set, so all-zero power-up
  // storage reads back as the defaults and reset never has to touch them.
  for (genvar k = 0; k < TAPS; k++) begin : g_dflt
    assign coeff_dflt[k] = COEFF_WIDTH'(default_coeff(TAPS, k));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    mac_c    = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          accept_c = 1'b1;
          state_d  = MAC;
        end
      end
      MAC: begin
        mac_c = 1'b1;
        if (tap_q == LAST_TAP) begin
          last_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign coeff_wr_c = coeff_we && (state_q == IDLE) && !rst_in && (32'(coeff_addr) < TAPS);

  // Tap k pairs with the sample k steps older than the newest one.
  always_comb begin
    if (wr_ptr_q >= tap_q) begin
      rd_idx_c = wr_ptr_q - tap_q;
    end else begin
      rd_idx_c = AW'(TAPS) + wr_ptr_q - tap_q;
    end
    coeff_rd_c = coeff_q[tap_q] ^ coeff_dflt[tap_q];
    prod_c     = PROD_W'(hist_q[rd_idx_c]) * PROD_W'(coeff_rd_c);
    acc_next_c = acc_q + ACC_W'(prod_c);
  end

  fir_round_sat #(
    .IN_W      (ACC_W),
    .OUT_W     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .value  (acc_next_c),
    .result (result_c)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q       <= '0;
      tap_q          <= '0;
      acc_q          <= '0;
      hist_q         <= '{default: '0};
      filtered_audio <= '0;
      data_ready     <= 1'b0;
      in_ready       <= 1'b1;
      overrun        <= 1'b0;
    end else begin
      data_ready <= last_c;
      in_ready   <= (state_d == IDLE);
      if (valid_in && !in_ready) begin
        overrun <= 1'b1;
      end
      if (accept_c) begin
        hist_q[wr_ptr_q] <= audio_in;
        acc_q            <= '0;
        tap_q            <= '0;
      end
      if (mac_c) begin
        acc_q <= acc_next_c;
        tap_q <= tap_q + AW'(1);
        if (last_c) begin
          tap_q          <= '0;
          filtered_audio <= result_c;
          wr_ptr_q       <= (wr_ptr_q == LAST_TAP) ? '0 : wr_ptr_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (coeff_wr_c) begin
      coeff_q[coeff_addr] <= coeff_data ^ coeff_dflt[coeff_addr];
    end
  end

endmodule
